// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
// End-of-test monitor for the single-cycle RISC-V core. It watches the program
// counter for the self-branch halt idiom and checks a fixed set of word stores.
// It also applies a cycle budget. The verdict is held on registered outputs so
// that it can drive LEDs or a UART on the board as well as a simulation bench.
//
// d_dt encoding follows funct3[1:0] of the load/store instruction:
//   2'b00 byte, 2'b01 half, 2'b10 word (2'b11 unused, such stores are ignored).
module riscv_test_monitor #(
  parameter int                   N_CHK          = 2,
  parameter logic [N_CHK*32-1:0]  CHK_ADDR       = {32'd100, 32'd96},
  parameter logic [N_CHK*32-1:0]  CHK_DATA       = {32'd25, 32'd7},
  parameter int                   HALT_REPEAT    = 3,
  parameter int                   TIMEOUT_CYCLES = 1000,
  parameter int                   CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wd,
  input  logic              d_we,
  input  logic [1:0]        d_dt,
  output logic              done,
  output logic [1:0]        status,
  output logic [N_CHK-1:0]  hit_mask,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  // The stall counter only has to count up to HALT_REPEAT-1.
  localparam int STALL_W = (HALT_REPEAT > 2) ? $clog2(HALT_REPEAT) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(HALT_REPEAT - 1);
  localparam logic [STALL_W-1:0] HALT_AT   = STALL_W'(HALT_REPEAT - 2);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  // State codes equal the status codes reported to the outside world.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [1:0]          status_q, status_d;
  logic [N_CHK-1:0]    hit_q, hit_d;
  logic [N_CHK-1:0]    seen_q, seen_d;
  logic [N_CHK-1:0]    bad_q, bad_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [31:0]         prev_pc_q, prev_pc_d;
  logic                prev_vld_q, prev_vld_d;

  // Per-check decode of the current data-memory access.
  logic [N_CHK-1:0]    word_hit;   // full-word store to exactly this address
  logic [N_CHK-1:0]    sub_hit;    // half/byte store touching this word
  logic [N_CHK-1:0]    data_eq;    // write data equals the expected value

  for (genvar gi = 0; gi < N_CHK; gi++) begin : g_chk
    assign word_hit[gi] = d_we && (d_dt == DT_WORD) &&
                          (d_addr == CHK_ADDR[32*gi +: 32]);
    assign sub_hit[gi]  = d_we && ((d_dt == DT_HALF) || (d_dt == DT_BYTE)) &&
                          (d_addr[31:2] == CHK_ADDR[32*gi+2 +: 30]);
    assign data_eq[gi]  = (d_wd == CHK_DATA[32*gi +: 32]);
  end

  // Check state including this cycle's store, so a store on the halting
  // edge still counts towards the verdict.
  logic [N_CHK-1:0] seen_n, hit_n, bad_n;
  logic             same_pc, halt;

  assign seen_n  = seen_q | word_hit;
  assign hit_n   = (hit_q & ~(word_hit | sub_hit)) | (word_hit & data_eq);
  assign bad_n   = bad_q | sub_hit;
  assign same_pc = prev_vld_q && (pc == prev_pc_q);
  assign halt    = same_pc && (stall_q == HALT_AT);

  // Next-state and next-output logic; terminal states keep everything frozen.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    status_d   = status_q;
    hit_d      = hit_q;
    seen_d     = seen_q;
    bad_d      = bad_q;
    cycles_d   = cycles_q;
    stall_d    = stall_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;

    if (state_q == ST_RUN) begin
      cycles_d   = (cycles_q == {CNT_W{1'b1}}) ? cycles_q : cycles_q + 1'b1;
      prev_pc_d  = pc;
      prev_vld_d = 1'b1;
      if (same_pc) begin
        stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
      end else begin
        stall_d = '0;
      end
      seen_d = seen_n;
      hit_d  = hit_n;
      bad_d  = bad_n;

      // A halt on the last budgeted cycle still produces a pass/fail verdict.
      if (halt) begin
        state_d = (&(seen_n & hit_n & ~bad_n)) ? ST_PASS : ST_FAIL;
      end else if (cycles_q == TO_LAST) begin
        state_d = ST_TIMEOUT;
      end
    end

    done_d   = (state_d != ST_RUN);
    status_d = state_d;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      done_q     <= 1'b0;
      status_q   <= 2'b00;
      hit_q      <= '0;
      seen_q     <= '0;
      bad_q      <= '0;
      cycles_q   <= '0;
      stall_q    <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      status_q   <= status_d;
      hit_q      <= hit_d;
      seen_q     <= seen_d;
      bad_q      <= bad_d;
      cycles_q   <= cycles_d;
      stall_q    <= stall_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign done     = done_q;
  assign status   = status_q;
  assign hit_mask = hit_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: directed program traces plus randomized pc and
// store streams, compared every cycle against a simple behavioural model.
module tb_riscv_test_monitor;

  localparam int HALT    = 3;
  localparam int TIMEOUT = 50;
  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, d_addr = '0, d_wd = '0;
  logic        d_we = 1'b0;
  logic [1:0]  d_dt = DT_WORD;
  logic        done;
  logic [1:0]  status;
  logic [1:0]  hit_mask;
  logic [31:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_test_monitor #(
    .N_CHK(2),
    .CHK_ADDR({32'd100, 32'd96}),
    .CHK_DATA({32'd25, 32'd7}),
    .HALT_REPEAT(HALT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .d_addr(d_addr), .d_wd(d_wd),
    .d_we(d_we), .d_dt(d_dt), .done(done), .status(status),
    .hit_mask(hit_mask), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [31:0] chk_addr [2] = '{32'd96, 32'd100};
  logic [31:0] chk_data [2] = '{32'd7, 32'd25};

  logic [1:0]  m_status;
  logic [31:0] m_cycles;
  logic [1:0]  m_hit, m_seen, m_bad;
  int          m_run;      // length of the current run of equal pc samples
  logic [31:0] m_last;

  task automatic model_reset();
    m_status = 2'b00; m_cycles = 0; m_hit = 0; m_seen = 0; m_bad = 0;
    m_run = 0; m_last = 0;
  endtask

  task automatic model_step(input logic [31:0] p, input logic we,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] dt);
    if (m_status != 2'b00) return;
    if (m_run > 0 && p == m_last) m_run++;
    else m_run = 1;
    m_last = p;
    for (int i = 0; i < 2; i++) begin
      if (we && dt == DT_WORD && a == chk_addr[i]) begin
        m_seen[i] = 1'b1;
        m_hit[i]  = (wd == chk_data[i]);
      end else if (we && (dt == DT_BYTE || dt == DT_HALF) &&
                   (a / 4) == (chk_addr[i] / 4)) begin
        m_bad[i] = 1'b1;
        m_hit[i] = 1'b0;
      end
    end
    m_cycles = m_cycles + 1;
    if (m_run >= HALT)
      m_status = (m_seen == 2'b11 && m_hit == 2'b11 && m_bad == 2'b00) ? 2'b01 : 2'b10;
    else if (m_cycles == TIMEOUT)
      m_status = 2'b11;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic drive_cycle(input logic [31:0] p, input logic we,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] dt);
    pc = p; d_we = we; d_addr = a; d_wd = wd; d_dt = dt;
    @(posedge clk);
    model_step(p, we, a, wd, dt);
    #1;
  endtask

  task automatic assert_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    d_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    assert_reset();
    #1;
    n_checks++;
    if ({done, status, hit_mask, cycles} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state got done=%b st=%b hit=%b cyc=%0d want all zero",
               done, status, hit_mask, cycles);
    end
    release_reset();
    $display("test_reset done");
  endtask

  // Reference program: pc steps by 4 to 80, stores 7@96 at pc 68 and
  // wd100@100 at pc 76, then branches to itself at 80.
  task automatic run_program(input logic [31:0] wd100, input logic [1:0] want_st,
                             input logic [1:0] want_hit, input string tag);
    int first80 = -1;
    int done_at = -1;
    logic [31:0] p;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      p = (k <= 20) ? 32'(4 * k) : 32'd80;
      if (p == 68)      drive_cycle(p, 1'b1, 32'd96, 32'd7, DT_WORD);
      else if (p == 76) drive_cycle(p, 1'b1, 32'd100, wd100, DT_WORD);
      else              drive_cycle(p, 1'b0, $urandom, $urandom, DT_WORD);
      if (p == 80 && first80 < 0) first80 = k;
      n_checks++;
      if ({done, status, hit_mask, cycles} !== {m_status != 2'b00, m_status, m_hit, m_cycles}) begin
        n_fail++;
        $display("FAIL %s_cycle k=%0d got done=%b st=%b hit=%b cyc=%0d want done=%b st=%b hit=%b cyc=%0d",
                 tag, k, done, status, hit_mask, cycles, m_status != 2'b00, m_status, m_hit, m_cycles);
      end
      if (done === 1'b1) done_at = k;
    end
    n_checks++;
    if (done_at < 0 || status !== want_st || hit_mask !== want_hit) begin
      n_fail++;
      $display("FAIL %s_verdict got done=%b st=%b hit=%b want done=1 st=%b hit=%b",
               tag, done, status, hit_mask, want_st, want_hit);
    end
    n_checks++;
    if (done_at < 0 || first80 < 0 || (done_at - first80 + 1) > 3) begin
      n_fail++;
      $display("FAIL %s_latency got %0d cycles after pc=80 want <=3", tag, done_at - first80 + 1);
    end
    $display("%s finished: status=%b hit=%b cycles=%0d", tag, status, hit_mask, cycles);
  endtask

  task automatic test_reference_pass();
    assert_reset(); release_reset();
    run_program(32'd25, 2'b01, 2'b11, "ref_pass");
  endtask

  task automatic test_data_fail();
    assert_reset(); release_reset();
    run_program(32'd26, 2'b10, 2'b01, "data_fail");
  endtask

  task automatic test_timeout();
    assert_reset(); release_reset();
    for (int k = 0; k < 60; k++) begin
      drive_cycle(32'(4 * k), 1'b0, 32'd0, 32'd0, DT_WORD);
      n_checks++;
      if ({done, status, hit_mask, cycles} !== {m_status != 2'b00, m_status, m_hit, m_cycles}) begin
        n_fail++;
        $display("FAIL timeout_cycle k=%0d got done=%b st=%b cyc=%0d want done=%b st=%b cyc=%0d",
                 k, done, status, cycles, m_status != 2'b00, m_status, m_cycles);
      end
    end
    n_checks++;
    if (status !== 2'b11 || cycles !== 32'd50 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_final got st=%b cyc=%0d done=%b want st=11 cyc=50 done=1",
               status, cycles, done);
    end
    $display("test_timeout finished: status=%b cycles=%0d", status, cycles);
  endtask

  task automatic test_byte_bad();
    assert_reset(); release_reset();
    drive_cycle(32'd0, 1'b1, 32'd97, 32'h55, DT_BYTE);
    drive_cycle(32'd4, 1'b1, 32'd96, 32'd7, DT_WORD);
    drive_cycle(32'd8, 1'b1, 32'd100, 32'd25, DT_WORD);
    for (int k = 0; k < 3; k++) drive_cycle(32'd12, 1'b0, 32'd0, 32'd0, DT_WORD);
    n_checks++;
    if (status !== 2'b10 || done !== 1'b1 || status !== m_status) begin
      n_fail++;
      $display("FAIL byte_bad got st=%b done=%b want st=10 done=1", status, done);
    end
    $display("test_byte_bad finished: status=%b hit=%b", status, hit_mask);
  endtask

  // Equal samples on edges 48, 49 and 50; edge 50 is also the last budgeted one.
  task automatic test_halt_at_timeout();
    assert_reset(); release_reset();
    for (int k = 0; k < 52; k++) begin
      if (k == 3)      drive_cycle(32'(4 * k), 1'b1, 32'd96, 32'd7, DT_WORD);
      else if (k == 5) drive_cycle(32'(4 * k), 1'b1, 32'd100, 32'd25, DT_WORD);
      else             drive_cycle((k < 47) ? 32'(4 * k) : 32'd1000, 1'b0, 32'd0, 32'd0, DT_WORD);
      n_checks++;
      if ({done, status, hit_mask, cycles} !== {m_status != 2'b00, m_status, m_hit, m_cycles}) begin
        n_fail++;
        $display("FAIL halt_edge_cycle k=%0d got st=%b cyc=%0d want st=%b cyc=%0d",
                 k, status, cycles, m_status, m_cycles);
      end
    end
    n_checks++;
    if (status !== 2'b01 || cycles !== 32'd50) begin
      n_fail++;
      $display("FAIL halt_wins got st=%b cyc=%0d want st=01 cyc=50", status, cycles);
    end
    $display("test_halt_at_timeout finished: status=%b cycles=%0d", status, cycles);
  endtask

  task automatic test_reset_mid();
    assert_reset(); release_reset();
    run_program(32'd25, 2'b01, 2'b11, "pre_reset");
    // Reset from PASS, observed before any clock edge.
    #2; rst = 1'b1; model_reset(); #1;
    n_checks++;
    if ({done, status, hit_mask, cycles} !== 37'd0) begin
      n_fail++;
      $display("FAIL async_reset_pass got done=%b st=%b hit=%b cyc=%0d want all zero",
               done, status, hit_mask, cycles);
    end
    release_reset();
    drive_cycle(32'd0, 1'b0, 32'd0, 32'd0, DT_WORD);
    drive_cycle(32'd4, 1'b1, 32'd96, 32'd7, DT_WORD);
    drive_cycle(32'd8, 1'b0, 32'd0, 32'd0, DT_WORD);
    #2; rst = 1'b1; model_reset(); #1;
    n_checks++;
    if ({done, status, hit_mask, cycles} !== 37'd0) begin
      n_fail++;
      $display("FAIL async_reset_run got done=%b st=%b hit=%b cyc=%0d want all zero",
               done, status, hit_mask, cycles);
    end
    release_reset();
    run_program(32'd25, 2'b01, 2'b11, "rerun");
  endtask

  task automatic test_random();
    logic [31:0] addrs [8] = '{32'd96, 32'd97, 32'd98, 32'd99, 32'd100, 32'd102, 32'd104, 32'd0};
    logic [31:0] p, a, wd;
    logic        we;
    logic [1:0]  dt;
    int          rep_pct;
    for (int it = 0; it < 30; it++) begin
      assert_reset(); release_reset();
      rep_pct = (it % 2 == 0) ? 10 : 40;
      p = $urandom_range(0, 15) * 4;
      for (int k = 0; k < 70; k++) begin
        if ($urandom_range(0, 99) >= rep_pct) p = $urandom_range(0, 15) * 4;
        we = ($urandom_range(0, 2) == 0);
        a  = addrs[$urandom_range(0, 7)];
        dt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : DT_WORD;
        if ($urandom_range(0, 1) == 0) wd = (a == 96) ? 32'd7 : (a == 100) ? 32'd25 : $urandom;
        else wd = $urandom_range(0, 30);
        drive_cycle(p, we, a, wd, dt);
        n_checks++;
        if ({done, status, hit_mask, cycles} !== {m_status != 2'b00, m_status, m_hit, m_cycles}) begin
          n_fail++;
          $display("FAIL random it=%0d k=%0d got done=%b st=%b hit=%b cyc=%0d want done=%b st=%b hit=%b cyc=%0d",
                   it, k, done, status, hit_mask, cycles, m_status != 2'b00, m_status, m_hit, m_cycles);
        end
      end
      $display("random run %0d: status=%b hit=%b cycles=%0d", it, status, hit_mask, cycles);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reference_pass();
    test_data_fail();
    test_timeout();
    test_byte_bad();
    test_halt_at_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
